// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// A pixel-clock divider produces p_tick. p_tick steps a horizontal counter,
// and the horizontal wrap steps a vertical counter. Every output is
// registered from the decode of the next-state counter values. This puts
// sync, blanking and strobes on the same edge as the counters, with no
// combinational glitches.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 2,
  parameter int CW        = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_MAX   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          h_end, v_end;
  logic          active_d, hs_win_d, vs_win_d;
  logic          video_on_q, hsync_q, vsync_q;
  logic          line_start_q, frame_start_q;

  // The divider only runs when enabled. p_tick is forced low while reset is
  // asserted, so no counter step can coincide with reset.
  always_comb begin
    div_d = div_q;
    if (en) begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
    end
  end

  assign p_tick = reset && en && (div_q == DIV_MAX);
  assign h_end  = (h_q == H_MAX);
  assign v_end  = (v_q == V_MAX);

  // Next-state raster position: h steps on every p_tick, and v steps on the horizontal wrap.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (p_tick) begin
      h_d = h_end ? '0 : h_q + CW'(1);
      if (h_end) begin
        v_d = v_end ? '0 : v_q + CW'(1);
      end
    end
  end

  // Decode of the next-state position, which the output registers load.
  always_comb begin
    active_d = (h_d < H_ACT) && (v_d < V_ACT);
    hs_win_d = (h_d >= HS_BEG) && (h_d <= HS_LAST);
    vs_win_d = (v_d >= VS_BEG) && (v_d <= VS_LAST);
  end

  // Counter and output registers. Outputs load on every edge, so they
  // simply reload their held values while en is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      video_on_q    <= active_d;
      hsync_q       <= hs_win_d ? HSYNC_POL : ~HSYNC_POL;
      vsync_q       <= vs_win_d ? VSYNC_POL : ~VSYNC_POL;
      line_start_q  <= p_tick && h_end;
      frame_start_q <= p_tick && h_end && v_end;
    end
  end

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. It runs two instances: the default 640x480
// timing, and a small 14x7 configuration that makes full frames short.
// A cycle model pushes the expected output vector of each instance at
// every rising edge. The tests pop that vector on the falling edge and
// compare it with the DUT outputs, alongside directed timing checks.
module tb_vga_timing_gen;

  logic clk;
  logic rst_d, en_d, rst_s, en_s;
  logic pt_d, hs_d, vs_d, vo_d, ls_d, fs_d;
  logic pt_s, hs_s, vs_s, vo_s, ls_s, fs_s;
  logic [10:0] px_d, py_d, px_s, py_s;
  logic [27:0] obs_d, obs_s, exp_d, exp_s;
  logic [27:0] q_d[$];
  logic [27:0] q_s[$];
  int md_div, md_h, md_v, ms_div, ms_h, ms_v;
  int checks, failures;

  vga_timing_gen u_def (
    .clk(clk), .reset(rst_d), .en(en_d), .p_tick(pt_d), .hsync(hs_d),
    .vsync(vs_d), .video_on(vo_d), .pixel_x(px_d), .pixel_y(py_d),
    .line_start(ls_d), .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .CW(11)
  ) u_small (
    .clk(clk), .reset(rst_s), .en(en_s), .p_tick(pt_s), .hsync(hs_s),
    .vsync(vs_s), .video_on(vo_s), .pixel_x(px_s), .pixel_y(py_s),
    .line_start(ls_s), .frame_start(fs_s)
  );

  assign obs_d = {pt_d, hs_d, vs_d, vo_d, ls_d, fs_d, px_d, py_d};
  assign obs_s = {pt_s, hs_s, vs_s, vo_s, ls_s, fs_s, px_s, py_s};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one rising edge of the raster generator.
  task automatic model_step(input bit rst, input bit en, input int cd,
                            input int ha, input int hf, input int hs, input int hb,
                            input int va, input int vf, input int vs, input int vb,
                            input bit hp, input bit vp,
                            inout int div, inout int h, inout int v,
                            output logic [27:0] ev);
    bit tick, ls, fs, pt, hw, vw, act;
    int ht, vt;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (!rst) begin
      div = 0; h = 0; v = 0;
      ev = {1'b0, ~hp, ~vp, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0};
    end else begin
      tick = en && (div == cd - 1);
      ls = 1'b0; fs = 1'b0;
      if (en) div = (div == cd - 1) ? 0 : div + 1;
      if (tick) begin
        if (h == ht - 1) begin
          h = 0; ls = 1'b1;
          if (v == vt - 1) begin v = 0; fs = 1'b1; end
          else v = v + 1;
        end else h = h + 1;
      end
      pt  = en && (div == cd - 1);
      hw  = (h >= ha + hf) && (h < ha + hf + hs);
      vw  = (v >= va + vf) && (v < va + vf + vs);
      act = (h < ha) && (v < va);
      ev = {pt, hw ? hp : ~hp, vw ? vp : ~vp, act, ls, fs, h[10:0], v[10:0]};
    end
  endtask

  // Scoreboard producer: the expected post-edge outputs of each instance.
  always @(posedge clk) begin
    logic [27:0] e;
    model_step(rst_d, en_d, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
               md_div, md_h, md_v, e);
    q_d.push_back(e);
    model_step(rst_s, en_s, 1, 8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b1,
               ms_div, ms_h, ms_v, e);
    q_s.push_back(e);
  end

  // Advance to the next falling edge and pop one expected vector per instance.
  task automatic tick();
    @(negedge clk);
    if (q_d.size() == 0 || q_s.size() == 0) begin
      $display("FAIL scoreboard_empty got d=%0d s=%0d entries, need 1", q_d.size(), q_s.size());
      failures++;
      $fatal(1, "scoreboard underrun");
    end
    exp_d = q_d.pop_front();
    exp_s = q_s.pop_front();
  endtask

  task automatic test_reset();
    rst_d = 1'b0; rst_s = 1'b0; en_d = 1'b1; en_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_d !== 28'h6000000) begin
        $display("FAIL reset_hold_def got %h need %h", obs_d, 28'h6000000);
        failures++;
      end
      checks++;
      if (obs_s !== 28'h0000000) begin
        $display("FAIL reset_hold_small got %h need %h", obs_s, 28'h0000000);
        failures++;
      end
    end
    rst_d = 1'b1; rst_s = 1'b1;
    tick();
    checks++;
    if (obs_d !== exp_d) begin
      $display("FAIL release_sb got %h need %h", obs_d, exp_d); failures++;
    end
    checks++;
    if ({vo_d, fs_d, ls_d, pt_d, px_d} !== {4'b1001, 11'd0}) begin
      $display("FAIL release_def got vo=%b fs=%b ls=%b pt=%b x=%0d need 1 0 0 1 0",
               vo_d, fs_d, ls_d, pt_d, px_d);
      failures++;
    end
    checks++;
    if ({vo_s, fs_s, pt_s} !== 3'b101) begin
      $display("FAIL release_small got vo=%b fs=%b pt=%b need 1 0 1", vo_s, fs_s, pt_s);
      failures++;
    end
  endtask

  task automatic test_free_run();
    int last_pt, per_bad, hs_cnt, hs_min, hs_max, vo_bad, last_ls, ls_bad, ls_n, fs_n;
    last_pt = -1; per_bad = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1;
    vo_bad = 0; last_ls = -1; ls_bad = 0; ls_n = 0; fs_n = 0;
    for (int c = 0; c < 4900; c++) begin
      tick();
      checks++;
      if (obs_d !== exp_d) begin
        $display("FAIL free_run_sb cyc=%0d got %h need %h", c, obs_d, exp_d); failures++;
      end
      if (pt_d) begin
        if (last_pt >= 0 && c - last_pt != 2) per_bad++;
        last_pt = c;
      end
      if (py_d == 11'd1 && hs_d == 1'b0) begin
        hs_cnt++;
        if (int'(px_d) < hs_min) hs_min = int'(px_d);
        if (int'(px_d) > hs_max) hs_max = int'(px_d);
      end
      if (vo_d && (px_d >= 11'd640 || py_d >= 11'd480)) vo_bad++;
      if (ls_d) begin
        ls_n++;
        if (last_ls >= 0 && c - last_ls != 1600) ls_bad++;
        last_ls = c;
      end
      if (fs_d) fs_n++;
    end
    checks++;
    if (per_bad !== 0) begin $display("FAIL ptick_period got %0d bad gaps need 0", per_bad); failures++; end
    checks++;
    if ({hs_cnt, hs_min, hs_max} !== {32'd192, 32'd656, 32'd751}) begin
      $display("FAIL hsync_window got clks=%0d x=%0d..%0d need 192 656..751", hs_cnt, hs_min, hs_max);
      failures++;
    end
    checks++;
    if (vo_bad !== 0) begin $display("FAIL video_on_blank got %0d need 0", vo_bad); failures++; end
    checks++;
    if (ls_bad !== 0 || ls_n !== 3) begin
      $display("FAIL line_spacing got bad=%0d pulses=%0d need 0 3", ls_bad, ls_n); failures++;
    end
    checks++;
    if (fs_n !== 0) begin $display("FAIL no_frame_start got %0d need 0", fs_n); failures++; end
  endtask

  task automatic test_wrap();
    bit found;
    logic [10:0] row;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      tick();
      if (px_d == 11'd799 && pt_d) begin found = 1'b1; row = py_d; end
    end
    checks++;
    if (!found) begin $display("FAIL wrap_line_timeout got none need x=799"); failures++; end
    else begin
      tick();
      checks++;
      if ({px_d, py_d, ls_d, fs_d} !== {11'd0, row + 11'd1, 2'b10}) begin
        $display("FAIL line_wrap got (%0d,%0d) ls=%b fs=%b need (0,%0d) 1 0", px_d, py_d, ls_d, fs_d, row + 11'd1);
        failures++;
      end
      tick();
      checks++;
      if (ls_d !== 1'b0) begin $display("FAIL line_pulse_width got %b need 0", ls_d); failures++; end
    end
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (px_s == 11'd13 && py_s == 11'd2) found = 1'b1;
    end
    tick();
    checks++;
    if (!found || {px_s, py_s, ls_s, fs_s} !== {11'd0, 11'd3, 2'b10}) begin
      $display("FAIL small_line_wrap got (%0d,%0d) ls=%b fs=%b found=%b need (0,3) 1 0 1", px_s, py_s, ls_s, fs_s, found);
      failures++;
    end
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (px_s == 11'd13 && py_s == 11'd6) found = 1'b1;
    end
    tick();
    checks++;
    if (!found || {px_s, py_s, ls_s, fs_s} !== {11'd0, 11'd0, 2'b11}) begin
      $display("FAIL frame_wrap got (%0d,%0d) ls=%b fs=%b found=%b need (0,0) 1 1 1", px_s, py_s, ls_s, fs_s, found);
      failures++;
    end
    tick();
    checks++;
    if ({px_s, ls_s, fs_s} !== {11'd1, 2'b00}) begin
      $display("FAIL frame_pulse_width got x=%0d ls=%b fs=%b need 1 0 0", px_s, ls_s, fs_s);
      failures++;
    end
  endtask

  task automatic test_freeze();
    bit found;
    logic [27:0] snap;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      tick();
      if (px_d == 11'd300 && !pt_d) found = 1'b1;
    end
    checks++;
    if (!found) begin $display("FAIL freeze_timeout got none need x=300"); failures++; end
    snap = obs_d;
    en_d = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      checks++;
      if (obs_d !== exp_d || obs_d !== snap) begin
        $display("FAIL freeze_hold i=%0d got %h need %h", i, obs_d, snap); failures++;
      end
    end
    en_d = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      tick();
      if (pt_d) found = 1'b1;
    end
    tick();
    checks++;
    if (!found || px_d !== 11'd301) begin
      $display("FAIL freeze_resume got x=%0d tick=%b need 301 1", px_d, found); failures++;
    end
  endtask

  task automatic test_small_config();
    int pt_bad, hs_bad, vs_bad, last_fs, fs_bad, fs_n;
    pt_bad = 0; hs_bad = 0; vs_bad = 0; last_fs = -1; fs_bad = 0; fs_n = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      checks++;
      if (obs_s !== exp_s) begin
        $display("FAIL small_sb cyc=%0d got %h need %h", c, obs_s, exp_s); failures++;
      end
      if (pt_s !== 1'b1) pt_bad++;
      if (hs_s !== (px_s >= 11'd10 && px_s <= 11'd12)) hs_bad++;
      if (vs_s !== (py_s == 11'd5)) vs_bad++;
      if (fs_s) begin
        fs_n++;
        if (last_fs >= 0 && c - last_fs != 98) fs_bad++;
        last_fs = c;
      end
    end
    checks++;
    if (pt_bad !== 0) begin $display("FAIL small_ptick got %0d low need 0", pt_bad); failures++; end
    checks++;
    if (hs_bad !== 0 || vs_bad !== 0) begin
      $display("FAIL small_sync got hbad=%0d vbad=%0d need 0 0", hs_bad, vs_bad); failures++;
    end
    checks++;
    if (fs_bad !== 0 || fs_n !== 3) begin
      $display("FAIL small_frame_spacing got bad=%0d pulses=%0d need 0 3", fs_bad, fs_n); failures++;
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      tick();
      if (px_d == 11'd400) found = 1'b1;
    end
    checks++;
    if (!found) begin $display("FAIL mid_reset_timeout got none need x=400"); failures++; end
    rst_d = 1'b0;
    tick();
    checks++;
    if (obs_d !== 28'h6000000 || obs_d !== exp_d) begin
      $display("FAIL mid_reset got %h need %h", obs_d, 28'h6000000); failures++;
    end
    rst_d = 1'b1;
    tick();
    checks++;
    if (obs_d !== exp_d || {vo_d, fs_d, ls_d, pt_d, px_d, py_d} !== {4'b1001, 22'd0}) begin
      $display("FAIL mid_reset_release got %h need %h", obs_d, exp_d); failures++;
    end
    tick();
    checks++;
    if (obs_d !== exp_d || {pt_d, px_d} !== {1'b0, 11'd1}) begin
      $display("FAIL mid_reset_restart got pt=%b x=%0d need 0 1", pt_d, px_d); failures++;
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    md_div = 0; md_h = 0; md_v = 0; ms_div = 0; ms_h = 0; ms_v = 0;
    rst_d = 1'b0; rst_s = 1'b0; en_d = 1'b1; en_s = 1'b1;
    test_reset();
    test_free_run();
    test_wrap();
    test_freeze();
    test_small_config();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/raster timing generator. It is the next-generation replacement for the fixed 640x480 sync generator. Every horizontal and vertical interval is a parameter, as are the sync polarities and the pixel-clock divide ratio. It adds a run/freeze enable and one-clock line/frame start strobes. It sits between the system clock and the pixel pipeline: the pixel generator consumes `pixel_x`, `pixel_y` and `video_on`, and the DAC/connector consumes `hsync` and `vsync`.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels after active)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HSYNC_POL, 0, 1 = hsync active-high, 0 = active-low
- VSYNC_POL, 0, 1 = vsync active-high, 0 = active-low
- CLK_DIV, 2, clk cycles per pixel (>=1)
- CW, 11, width of pixel_x/pixel_y; must satisfy H_TOTAL, V_TOTAL <= 2^CW
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- en  in  1  1 = run, 0 = freeze divider and counters
- p_tick  out  1  pixel strobe, one clk wide
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- video_on  out  1  current pixel is in the active area
- pixel_x  out  CW  horizontal counter, 0..H_TOTAL-1
- pixel_y  out  CW  vertical counter, 0..V_TOTAL-1
- line_start  out  1  one-clk pulse, first cycle of a new line
- frame_start  out  1  one-clk pulse, first cycle of a new frame

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active, front porch, sync, back porch. The same order applies to frames.
- Divider: counter div_cnt counts 0..CLK_DIV-1 and wraps.
  - It advances only when en=1 and holds when en=0.
  - p_tick = en && (div_cnt == CLK_DIV-1), combinational. For CLK_DIV=1, p_tick = en.
- Horizontal counter h_cnt advances on a clk edge when p_tick=1.
  - At H_TOTAL-1 it wraps to 0 (h_end).
- Vertical counter v_cnt advances when p_tick && h_end.
  - At V_TOTAL-1 it wraps to 0 (v_end).
- Output registers load the decode of the *next-state* counter values on every clk edge, regardless of en. Outputs therefore change on the same edge as the counters, and are glitch-free:
  - video_on = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; default 656..751
  - vsync asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; default 490..491
  - pixel_x = h, pixel_y = v (raw count, not clamped to the active area)
  - line_start <= p_tick && h_end
  - frame_start <= p_tick && h_end && v_end
- Sync outputs drive the asserted level (POL) inside the sync window and the inverted level outside it.

## Timing
- Reset (reset=0 at a clk edge) sets, on that edge:
  - div_cnt=0, h_cnt=v_cnt=0
  - pixel_x=pixel_y=0, video_on=0, line_start=frame_start=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - p_tick=0 while reset is low
- First edge after reset release: video_on=1 (decode of 0,0). No frame_start or line_start pulse is issued for this first frame.
- With en=1 and default parameters:
  - p_tick is high every 2nd clk, starting with the 2nd clk after release.
  - One line = 800 ticks = 1600 clk. One frame = 525 lines = 840000 clk.
- line_start and frame_start are high for exactly one clk: the cycle in which pixel_x (and pixel_y) first read 0 after a wrap. On frame wrap, both pulse together.
- en=0: divider, counters and all outputs hold; p_tick=0. When en returns to 1 the divider resumes from its held value, so no pixel period is shortened.
- Reset mid-frame takes priority over en and the counters. The next cycle shows the reset values, with no strobe.
- Latency: 0 clk from the counter edge to the outputs. Outputs are valid for the entire pixel period.

## Test plan
- Reset hold: reset=0 for 5 clk with en=1 -> hsync=1, vsync=1, video_on=0, pixel_x=pixel_y=0, p_tick=0; first edge after release -> video_on=1, frame_start=0.
- Default free run for 2 frames:
  - p_tick period = 2 clk.
  - hsync low for 96 ticks from pixel_x=656 to 751.
  - video_on low for pixel_x>=640 or pixel_y>=480.
  - vsync low exactly on lines 490–491.
  - frame_start spacing = 840000 clk.
- Wrap corner: from (799,524), the next tick gives pixel_x=0, pixel_y=0, with line_start=frame_start=1 for one clk only. From (799,100), the next tick gives (0,101) with line_start=1 and frame_start=0.
- Freeze: drop en at pixel_x=300 for 17 clk -> all outputs constant and p_tick=0; after en=1 the next p_tick gives pixel_x=301.
- Small custom config: H 8/2/3/1 (total 14), V 4/1/1/1 (total 7), CLK_DIV=1, HSYNC_POL=VSYNC_POL=1 -> hsync high for pixel_x 10..12, vsync high for pixel_y 5, frame_start every 98 clk, p_tick=1 every cycle.
- Reset mid-frame at (400,200) with en=1 -> the next cycle shows (0,0) with reset output values and no strobes; counting restarts exactly as in the reset-hold scenario.
